// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserialiser: packs accepted serial bits into WIDTH-bit words.
// Latency: a word is presented on data_out/out_valid the cycle after its last bit is accepted.
// Backpressure: input is never stalled; a word completing while the previous one is unconsumed is dropped and flagged.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         data_in,
  input  logic                         in_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             data_out,
  output logic                         out_valid,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count,
  output logic                         overrun
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             word_done;
  logic             consume;

  // Shift direction fixed at elaboration: new bit enters the LSB end for MSB-first framing,
  // the MSB end for LSB-first framing, so the first bit ends up at the matching word end.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_nxt = {shift_q[WIDTH-2:0], data_in};
    end else begin : g_lsb_first
      assign shift_nxt = {data_in, shift_q[WIDTH-1:1]};
    end
  endgenerate

  assign word_done = in_valid && (cnt_q == LAST_BIT);
  assign consume   = vld_q && out_ready;

  // Next-state: accumulate bits, then load/hold/drop the completed word against the output handshake.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;

    if (in_valid) begin
      shift_d = shift_nxt;
      cnt_d   = word_done ? '0 : cnt_q + 1'b1;
    end

    // A consume on the completion edge frees the output slot, so the new word is loaded, not dropped.
    if (word_done && (!vld_q || consume)) begin
      dout_d = shift_nxt;
      vld_d  = 1'b1;
    end else if (word_done) begin
      ovr_d  = 1'b1;
    end else if (consume) begin
      vld_d  = 1'b0;
    end

    // Flush wins over any traffic on the same edge.
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
      dout_d  = '0;
      vld_d   = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // State registers; reset is asynchronous so outputs drop without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out  = dout_q;
  assign out_valid = vld_q;
  assign bit_count = cnt_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         clear;
  logic         data_in;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] dout_m, dout_l;
  logic         vld_m, vld_l;
  logic [3:0]   cnt_m, cnt_l;
  logic         ovr_m, ovr_l;

  int checks = 0;
  int errors = 0;

  // MSB-first and LSB-first instances share one stimulus stream.
  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .clear(clear), .data_in(data_in), .in_valid(in_valid),
    .out_ready(out_ready), .data_out(dout_m), .out_valid(vld_m), .bit_count(cnt_m), .overrun(ovr_m)
  );
  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .clear(clear), .data_in(data_in), .in_valid(in_valid),
    .out_ready(out_ready), .data_out(dout_l), .out_valid(vld_l), .bit_count(cnt_l), .overrun(ovr_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: list of bits received for the current word, and the word-level output state.
  bit           bitq[$];
  logic [W-1:0] mo_m, mo_l;
  logic         mvld, movr;

  task automatic model_reset();
    bitq.delete();
    mo_m = '0;
    mo_l = '0;
    mvld = 1'b0;
    movr = 1'b0;
  endtask

  task automatic model_step(input bit din, input bit iv, input bit rdy, input bit clr);
    bit           done;
    bit           cons;
    logic [W-1:0] wm, wl;
    done = 1'b0;
    wm   = '0;
    wl   = '0;
    if (clr) begin
      model_reset();
      return;
    end
    cons = mvld && rdy;
    if (iv) begin
      bitq.push_back(din);
      if (bitq.size() == W) begin
        // i-th received bit: position W-1-i when MSB first, position i when LSB first.
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = bitq[i];
          wl[i]     = bitq[i];
        end
        bitq.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!mvld || cons) begin
        mo_m = wm;
        mo_l = wl;
        mvld = 1'b1;
      end else begin
        movr = 1'b1;
      end
    end else if (cons) begin
      mvld = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("m.data_out", 64'(dout_m), 64'(mo_m));
    chk("l.data_out", 64'(dout_l), 64'(mo_l));
    chk("m.out_valid", 64'(vld_m), 64'(mvld));
    chk("l.out_valid", 64'(vld_l), 64'(mvld));
    chk("m.bit_count", 64'(cnt_m), 64'(bitq.size()));
    chk("l.bit_count", 64'(cnt_l), 64'(bitq.size()));
    chk("m.overrun", 64'(ovr_m), 64'(movr));
    chk("l.overrun", 64'(ovr_l), 64'(movr));
  endtask

  // One clock: drive at negedge, model at posedge, compare at the following negedge.
  task automatic tick(input bit din, input bit iv, input bit rdy, input bit clr);
    data_in   = din;
    in_valid  = iv;
    out_ready = rdy;
    clear     = clr;
    @(posedge clk);
    if (rst) model_step(din, iv, rdy, clr);
    @(negedge clk);
    chk_model();
  endtask

  // Stream a word bit 7 first; ready on the final edge can differ, optional idle gaps between bits.
  task automatic send_word(input logic [7:0] w, input bit rdy_rest, input bit rdy_last, input bit gaps);
    for (int i = W - 1; i >= 0; i--) begin
      if (gaps) tick(1'($urandom_range(0, 1)), 1'b0, rdy_rest, 1'b0);
      tick(w[i], 1'b1, (i == 0) ? rdy_last : rdy_rest, 1'b0);
    end
  endtask

  task automatic chk_const(input string tag, input logic [7:0] em, input logic [7:0] el,
                           input bit ev, input int ec, input bit eo);
    chk({tag, ".m.data"}, 64'(dout_m), 64'(em));
    chk({tag, ".l.data"}, 64'(dout_l), 64'(el));
    chk({tag, ".valid"}, 64'(vld_m), 64'(ev));
    chk({tag, ".count"}, 64'(cnt_m), 64'(ec));
    chk({tag, ".overrun"}, 64'(ovr_m), 64'(eo));
  endtask

  typedef struct {
    bit         din;
    bit         iv;
    bit         rdy;
    bit         clr;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
    bit         exp_vld;
    int         exp_cnt;
    bit         exp_ovr;
  } vec_t;

  vec_t vecs[10];
  logic [7:0] stream;

  initial begin
    // Bit stream 1,0,1,1,0,0,1,0 with ready held high, then two idle cycles.
    stream = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      vecs[i].din     = stream[7-i];
      vecs[i].iv      = 1'b1;
      vecs[i].rdy     = 1'b1;
      vecs[i].clr     = 1'b0;
      vecs[i].exp_m   = (i == 7) ? 8'hB2 : 8'h00;
      vecs[i].exp_l   = (i == 7) ? 8'h4D : 8'h00;
      vecs[i].exp_vld = (i == 7);
      vecs[i].exp_cnt = (i + 1) % 8;
      vecs[i].exp_ovr = 1'b0;
    end
    vecs[8] = '{din: 1'b1, iv: 1'b0, rdy: 1'b1, clr: 1'b0, exp_m: 8'hB2, exp_l: 8'h4D,
                exp_vld: 1'b0, exp_cnt: 0, exp_ovr: 1'b0};
    vecs[9] = '{din: 1'b0, iv: 1'b0, rdy: 1'b0, clr: 1'b0, exp_m: 8'hB2, exp_l: 8'h4D,
                exp_vld: 1'b0, exp_cnt: 0, exp_ovr: 1'b0};

    rst = 1'b0; clear = 1'b0; data_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_const("reset", 8'h00, 8'h00, 1'b0, 0, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    chk_const("post_reset_idle", 8'h00, 8'h00, 1'b0, 0, 1'b0);

    // Table-driven basic word, both bit orders.
    for (int v = 0; v < 10; v++) begin
      tick(vecs[v].din, vecs[v].iv, vecs[v].rdy, vecs[v].clr);
      chk_const($sformatf("vec%0d", v), vecs[v].exp_m, vecs[v].exp_l,
                vecs[v].exp_vld, vecs[v].exp_cnt, vecs[v].exp_ovr);
    end

    // Overrun: two words with ready low; second is dropped, then one consume.
    send_word(8'hB2, 1'b0, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0, 1'b0);
    chk_const("overrun", 8'hB2, 8'h4D, 1'b1, 0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk_const("overrun_consume", 8'hB2, 8'h4D, 1'b0, 0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk_const("clear_after_ovr", 8'h00, 8'h00, 1'b0, 0, 1'b0);

    // Consume on the exact completion edge of the second word.
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b1, 1'b0);
    chk_const("same_edge", 8'h5A, 8'h5A, 1'b1, 0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-word, between clock edges.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk_const("async_rst", 8'h00, 8'h00, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    chk_const("rst_release", 8'h00, 8'h00, 1'b0, 0, 1'b0);
    send_word(8'hA5, 1'b1, 1'b1, 1'b0);
    chk_const("after_rst", 8'hA5, 8'hA5, 1'b1, 0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);

    // Gaps between bits, then overrun, then clear mid-word with valid/ready asserted.
    send_word(8'hC3, 1'b0, 1'b0, 1'b1);
    chk_const("gaps", 8'hC3, 8'hC3, 1'b1, 0, 1'b0);
    send_word(8'h81, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk_const("pre_clear", 8'hC3, 8'hC3, 1'b1, 3, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    chk_const("clear", 8'h00, 8'h00, 1'b0, 0, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
